// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Mode codes, active-low glyphs (bit order g..a) and helpers
//               shared by the seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [1:0] MODE_NUM   = 2'd0;
    localparam logic [1:0] MODE_ERR   = 2'd1;
    localparam logic [1:0] MODE_DONE  = 2'd2;
    localparam logic [1:0] MODE_BLANK = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_N     = 7'b0101011;

    function automatic logic [6:0] to_7seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // ceil(width * log10(2)) + 1, kept in integer arithmetic
    function automatic int bcd_digits(input int width);
        return (width * 302 + 999) / 1000 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Serial double-dabble converter, one shift+add3 step per cycle,
//               VALUE_W steps per conversion with a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VALUE_W    = 8,
    parameter int BCD_DIGITS = bcd_digits(VALUE_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [VALUE_W-1:0]      i_value,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*BCD_DIGITS-1:0] o_bcd
);

    localparam int c_cnt_w = $clog2(VALUE_W + 1);

    logic                    r_busy;
    logic                    r_done;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [VALUE_W-1:0]      r_bin;
    logic [4*BCD_DIGITS-1:0] r_bcd;
    logic [4*BCD_DIGITS-1:0] w_adj;
    logic [4*BCD_DIGITS-1:0] w_step;

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (w_adj[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = w_adj[4*k +: 4] + 4'd3;
            end
        end
        w_step = {w_adj[4*BCD_DIGITS-2:0], r_bin[VALUE_W-1]};
    end

    // The first step happens on the start edge itself; the BCD register starts
    // at zero there, so no add3 correction is needed for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_bin  <= '0;
            r_bcd  <= '0;
        end else if (!r_busy) begin
            if (i_start) begin
                r_busy <= 1'b1;
                r_done <= (VALUE_W == 1);
                r_cnt  <= c_cnt_w'(VALUE_W - 1);
                r_bin  <= i_value << 1;
                r_bcd  <= (4*BCD_DIGITS)'(i_value[VALUE_W-1]);
            end
        end else if (r_done) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_bcd <= w_step;
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt - c_cnt_w'(1);
            if (r_cnt == c_cnt_w'(1)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed N-digit seven-segment driver with serial BCD
//               conversion, leading-zero blanking, overflow dashes and blink.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 8,
    parameter int TRAIL_ZERO = 1,
    parameter int LZB        = 1,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [VALUE_W-1:0]    in_value,
    input  logic [1:0]            in_mode,
    input  logic                  in_blink,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  overflow
);

    localparam int c_bcd_digits = bcd_digits(VALUE_W);
    localparam int c_field      = NUM_DIGITS - TRAIL_ZERO;
    localparam int c_pad        = (NUM_DIGITS > c_bcd_digits) ? NUM_DIGITS : c_bcd_digits;
    localparam int c_idx_w      = $clog2(NUM_DIGITS);
    localparam int c_scan_w     = $clog2(SCAN_DIV + 1);
    localparam int c_blink_w    = $clog2(BLINK_DIV + 1);

    logic                          w_accept;
    logic                          w_busy;
    logic                          w_done;
    logic [4*c_bcd_digits-1:0]     w_bcd;
    logic [4*c_pad-1:0]            w_bcd_pad;
    logic [NUM_DIGITS-1:0][6:0]    w_frame;
    logic                          w_ovf;
    logic                          w_seen;
    logic [3:0]                    w_dig;
    logic [NUM_DIGITS-1:0]         w_onehot;

    logic [1:0]                    r_mode;
    logic                          r_blink_req;
    logic [NUM_DIGITS-1:0][6:0]    r_frame;
    logic                          r_frame_blink;
    logic                          r_overflow;
    logic [c_scan_w-1:0]           r_scan_cnt;
    logic [c_idx_w-1:0]            r_index;
    logic [c_blink_w-1:0]          r_blink_cnt;
    logic                          r_phase;
    logic [6:0]                    r_seg_n;
    logic [NUM_DIGITS-1:0]         r_an_n;

    assign in_ready = ~rst & ~w_busy;
    assign w_accept = in_valid & in_ready;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .BCD_DIGITS (c_bcd_digits)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept),
        .i_value (in_value),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    assign w_bcd_pad = (4*c_pad)'(w_bcd);

    // Next frame, built from the finished BCD result and the captured mode
    always_comb begin
        w_frame = {NUM_DIGITS{SEG_BLANK}};
        w_ovf   = 1'b0;
        w_seen  = 1'b0;
        w_dig   = 4'd0;
        case (r_mode)
            MODE_NUM: begin
                for (int k = c_field; k < c_pad; k++) begin
                    if (w_bcd_pad[4*k +: 4] != 4'd0) begin
                        w_ovf = 1'b1;
                    end
                end
                for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                    if (w_ovf) begin
                        w_frame[i] = SEG_DASH;
                    end else if (i < TRAIL_ZERO) begin
                        w_frame[i] = to_7seg(4'd0);
                    end else begin
                        w_dig = w_bcd_pad[4*(i-TRAIL_ZERO) +: 4];
                        if (w_dig != 4'd0) begin
                            w_seen = 1'b1;
                        end
                        if ((LZB != 0) && !w_seen && (i != TRAIL_ZERO)) begin
                            w_frame[i] = SEG_BLANK;
                        end else begin
                            w_frame[i] = to_7seg(w_dig);
                        end
                    end
                end
            end
            MODE_ERR: begin
                w_frame[NUM_DIGITS-1] = SEG_E;
                w_frame[NUM_DIGITS-2] = SEG_R;
                w_frame[NUM_DIGITS-3] = SEG_R;
            end
            MODE_DONE: begin
                w_frame[NUM_DIGITS-1] = SEG_D;
                w_frame[NUM_DIGITS-2] = SEG_O;
                w_frame[NUM_DIGITS-3] = SEG_N;
                w_frame[NUM_DIGITS-4] = SEG_E;
            end
            default: begin
                w_frame = {NUM_DIGITS{SEG_BLANK}};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode        <= MODE_NUM;
            r_blink_req   <= 1'b0;
            r_frame       <= {NUM_DIGITS{SEG_BLANK}};
            r_frame_blink <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode      <= in_mode;
                r_blink_req <= in_blink;
            end
            if (w_done) begin
                r_frame       <= w_frame;
                r_frame_blink <= r_blink_req;
                r_overflow    <= w_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_index    <= '0;
        end else if (r_scan_cnt == c_scan_w'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_index    <= (r_index == c_idx_w'(NUM_DIGITS - 1)) ? '0 : r_index + c_idx_w'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + c_scan_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == c_blink_w'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
        end
    end

    always_comb begin
        w_onehot          = '0;
        w_onehot[r_index] = 1'b1;
    end

    // Outputs lag index/frame by one cycle so a simultaneous scan advance and
    // frame update appear together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_n <= SEG_BLANK;
            r_an_n  <= '1;
        end else begin
            r_seg_n <= (r_frame_blink && r_phase) ? SEG_BLANK : r_frame[r_index];
            r_an_n  <= ~w_onehot;
        end
    end

    assign seg_n    = r_seg_n;
    assign an_n     = r_an_n;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench driving two differently configured
//               drivers from one stimulus stream against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    typedef logic [5:0][6:0] frame_t;
    typedef struct {
        logic [1:0]      mode;
        int              value;
        logic [3:0][6:0] exp_a;
        bit              exp_ovf;
    } vec_t;

    localparam int NA = 4, VWA = 10, SDA = 2, BDA = 4;
    localparam int NB = 6, VWB = 8,  SDB = 3, BDB = 5;

    localparam logic [6:0] S_0 = 7'b1000000, S_1 = 7'b1111001, S_2 = 7'b0100100;
    localparam logic [6:0] S_3 = 7'b0110000, S_5 = 7'b0010010, S_9 = 7'b0010000;
    localparam logic [6:0] S_BL = 7'h7F, S_DASH = 7'b0111111, S_E = 7'b0000110;
    localparam logic [6:0] S_R = 7'b0101111, S_D = 7'b0100001, S_O = 7'b0100011;
    localparam logic [6:0] S_N = 7'b0101011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [9:0] in_value = '0;
    logic [1:0] in_mode = '0;
    logic       in_blink = 1'b0;

    logic       ready_a, ovf_a, ready_b, ovf_b;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a;
    logic [5:0] an_b;

    int checks = 0;
    int failures = 0;
    int idx_a[$], idx_b[$];
    bit blk_a[$], blk_b[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(NA), .VALUE_W(VWA), .TRAIL_ZERO(1), .LZB(1),
        .SCAN_DIV(SDA), .BLINK_DIV(BDA)
    ) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a),
        .in_value(in_value), .in_mode(in_mode), .in_blink(in_blink),
        .seg_n(seg_a), .an_n(an_a), .overflow(ovf_a)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(NB), .VALUE_W(VWB), .TRAIL_ZERO(0), .LZB(0),
        .SCAN_DIV(SDB), .BLINK_DIV(BDB)
    ) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b),
        .in_value(in_value[7:0]), .in_mode(in_mode), .in_blink(in_blink),
        .seg_n(seg_b), .an_n(an_b), .overflow(ovf_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        logic [6:0] g [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return g[d];
    endfunction

    // Display contents derived from the decimal value directly
    function automatic frame_t model(input int n, input int tz, input int lzb,
                                     input int value, input int mode, output bit ovf);
        frame_t f;
        int lim, p;
        f = '1;
        ovf = 1'b0;
        case (mode)
            0: begin
                lim = 1;
                for (int i = 0; i < n - tz; i++) lim *= 10;
                if (value >= lim) begin
                    ovf = 1'b1;
                    for (int i = 0; i < n; i++) f[i] = S_DASH;
                end else begin
                    for (int i = 0; i < n; i++) begin
                        if (i < tz) f[i] = glyph(0);
                        else begin
                            p = 1;
                            for (int k = 0; k < i - tz; k++) p *= 10;
                            if (lzb != 0 && i > tz && value < p) f[i] = S_BL;
                            else f[i] = glyph((value / p) % 10);
                        end
                    end
                end
            end
            1: begin f[n-1] = S_E; f[n-2] = S_R; f[n-3] = S_R; end
            2: begin f[n-1] = S_D; f[n-2] = S_O; f[n-3] = S_N; f[n-4] = S_E; end
            default: ;
        endcase
        return f;
    endfunction

    function automatic int zero_pos(input logic [5:0] an);
        int pos = -1;
        int cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (an[i] === 1'b0) begin pos = i; cnt++; end
            else if (an[i] !== 1'b1) cnt += 10;
        end
        return (cnt == 1) ? pos : -1;
    endfunction

    function automatic bit scan_ok(input int idx[$], input int div, input int n);
        int run = 1;
        bit first = 1'b1;
        if (idx.size() == 0 || idx[0] < 0) return 1'b0;
        for (int t = 1; t < idx.size(); t++) begin
            if (idx[t] < 0) return 1'b0;
            if (idx[t] == idx[t-1]) begin
                run++;
                if (run > div) return 1'b0;
            end else begin
                if (idx[t] != (idx[t-1] + 1) % n) return 1'b0;
                if (!first && run != div) return 1'b0;
                first = 1'b0;
                run = 1;
            end
        end
        return !first;
    endfunction

    function automatic bit run_ok(input bit b[$], input int div);
        int run = 1;
        int trans = 0;
        for (int t = 1; t < b.size(); t++) begin
            if (b[t] == b[t-1]) begin
                run++;
                if (run > div) return 1'b0;
            end else begin
                if (trans > 0 && run != div) return 1'b0;
                trans++;
                run = 1;
            end
        end
        return trans >= 2;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!(ready_a === 1'b1 && ready_b === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({tag, "_ready_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic load(input int mode, input int value, input logic blink, input string tag);
        int low_a = 0, low_b = 0, n = 0;
        wait_ready(tag);
        in_valid = 1'b1; in_mode = 2'(mode); in_value = 10'(value); in_blink = blink;
        @(posedge clk);
        #1 in_valid = 1'b0;
        do begin
            @(negedge clk);
            if (ready_a !== 1'b1) low_a++;
            if (ready_b !== 1'b1) low_b++;
            n++;
        end while (!(ready_a === 1'b1 && ready_b === 1'b1) && n < 60);
        chk({tag, "_busy_cycles_a"}, 64'(low_a), 64'(VWA));
        chk({tag, "_busy_cycles_b"}, 64'(low_b), 64'(VWB));
    endtask

    // Reassemble each display from one full scan of both drivers
    task automatic read_frames(input string tag, output frame_t fa, output frame_t fb);
        int ia, ib;
        bit oka = 1'b1, okb = 1'b1;
        fa = '1; fb = '1;
        for (int i = 0; i < NA; i++) fa[i] = 'x;
        for (int i = 0; i < NB; i++) fb[i] = 'x;
        @(posedge clk);
        for (int c = 0; c < NB * SDB + 2; c++) begin
            @(negedge clk);
            ia = zero_pos({2'b11, an_a});
            ib = zero_pos(an_b);
            if (ia < 0) oka = 1'b0; else fa[ia] = seg_a;
            if (ib < 0) okb = 1'b0; else fb[ib] = seg_b;
        end
        chk({tag, "_an_onehot_a"}, 64'(oka), 64'd1);
        chk({tag, "_an_onehot_b"}, 64'(okb), 64'd1);
    endtask

    task automatic check_load(input string tag, input int mode, input int value);
        frame_t fa, fb, ea, eb;
        bit oa, ob;
        ea = model(NA, 1, 1, value, mode, oa);
        eb = model(NB, 0, 0, value % 256, mode, ob);
        read_frames(tag, fa, fb);
        chk({tag, "_frame_a"}, 64'(fa), 64'(ea));
        chk({tag, "_ovf_a"}, 64'(ovf_a), 64'(oa));
        chk({tag, "_frame_b"}, 64'(fb), 64'(eb));
        chk({tag, "_ovf_b"}, 64'(ovf_b), 64'(ob));
    endtask

    task automatic collect(input int len);
        idx_a.delete(); idx_b.delete(); blk_a.delete(); blk_b.delete();
        @(posedge clk);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            idx_a.push_back(zero_pos({2'b11, an_a}));
            idx_b.push_back(zero_pos(an_b));
            blk_a.push_back(seg_a === S_BL);
            blk_b.push_back(seg_b === S_BL);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t fa, fb, ea;
        bit oa;
        int edges[8] = '{0, 9, 10, 99, 100, 999, 1000, 1023};
        int mode, value, nb;

        vecs[0] = '{2'd0, 123,  {S_1, S_2, S_3, S_0},       1'b0};
        vecs[1] = '{2'd0, 5,    {S_BL, S_BL, S_5, S_0},     1'b0};
        vecs[2] = '{2'd0, 0,    {S_BL, S_BL, S_0, S_0},     1'b0};
        vecs[3] = '{2'd0, 1000, {S_DASH, S_DASH, S_DASH, S_DASH}, 1'b1};
        vecs[4] = '{2'd1, 0,    {S_E, S_R, S_R, S_BL},      1'b0};
        vecs[5] = '{2'd0, 999,  {S_9, S_9, S_9, S_0},       1'b0};
        vecs[6] = '{2'd2, 7,    {S_D, S_O, S_N, S_E},       1'b0};
        vecs[7] = '{2'd3, 55,   {S_BL, S_BL, S_BL, S_BL},   1'b0};
        vecs[8] = '{2'd0, 10,   {S_BL, S_1, S_0, S_0},      1'b0};
        vecs[9] = '{2'd0, 100,  {S_1, S_0, S_0, S_0},       1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs_a", {ready_a, ovf_a, seg_a, an_a}, {1'b0, 1'b0, S_BL, 4'hF});
        chk("reset_outputs_b", {ready_b, ovf_b, seg_b, an_b}, {1'b0, 1'b0, S_BL, 6'h3F});
        rst = 1'b0;
        @(negedge clk);
        chk("first_scan_a", {ready_a, seg_a, an_a}, {1'b1, S_BL, 4'b1110});
        chk("first_scan_b", {ready_b, seg_b, an_b}, {1'b1, S_BL, 6'b111110});

        for (int i = 0; i < 10; i++) begin
            load(vecs[i].mode, vecs[i].value, 1'b0, $sformatf("vec%0d", i));
            ea = '1;
            ea[3:0] = vecs[i].exp_a;
            read_frames($sformatf("vec%0d", i), fa, fb);
            chk($sformatf("vec%0d_frame_a", i), 64'(fa), 64'(ea));
            chk($sformatf("vec%0d_ovf_a", i), 64'(ovf_a), 64'(vecs[i].exp_ovf));
            ea = model(NB, 0, 0, vecs[i].value % 256, vecs[i].mode, oa);
            chk($sformatf("vec%0d_frame_b", i), 64'(fb), 64'(ea));
            chk($sformatf("vec%0d_ovf_b", i), 64'(ovf_b), 64'(oa));
        end

        // Scan order and dwell, then blink windows with scanning still running
        load(0, 123, 1'b0, "scan");
        collect(40);
        chk("scan_seq_a", 64'(scan_ok(idx_a, SDA, NA)), 64'd1);
        chk("scan_seq_b", 64'(scan_ok(idx_b, SDB, NB)), 64'd1);
        nb = 0;
        foreach (blk_a[t]) nb += int'(blk_a[t]) + int'(blk_b[t]);
        chk("scan_no_blank", 64'(nb), 64'd0);
        load(0, 123, 1'b1, "blink");
        collect(40);
        chk("blink_scan_a", 64'(scan_ok(idx_a, SDA, NA)), 64'd1);
        chk("blink_scan_b", 64'(scan_ok(idx_b, SDB, NB)), 64'd1);
        chk("blink_runs_a", 64'(run_ok(blk_a, BDA)), 64'd1);
        chk("blink_runs_b", 64'(run_ok(blk_b, BDB)), 64'd1);

        // A load request while converting is dropped
        wait_ready("busy");
        in_valid = 1'b1; in_mode = 2'd0; in_value = 10'd42; in_blink = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1; in_mode = 2'd2; in_value = 10'd777;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_ready_low", {ready_a, ready_b}, 2'b00);
        wait_ready("busy_end");
        check_load("busy", 0, 42);

        // Reset part-way through a conversion leaves a blank frame
        wait_ready("rstmid");
        in_valid = 1'b1; in_mode = 2'd0; in_value = 10'd456;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_outputs", {ready_a, ready_b, seg_a, seg_b, an_a, an_b},
            {1'b0, 1'b0, S_BL, S_BL, 4'hF, 6'h3F});
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", {ready_a, ready_b}, 2'b11);
        repeat (15) @(negedge clk);
        read_frames("rstmid", fa, fb);
        chk("rstmid_frame_a", 64'(fa), 64'(frame_t'('1)));
        chk("rstmid_frame_b", 64'(fb), 64'(frame_t'('1)));
        chk("rstmid_ovf", {ovf_a, ovf_b}, 2'b00);

        for (int r = 0; r < 25; r++) begin
            mode  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            value = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 7)]
                                                : int'($urandom_range(0, 1023));
            load(mode, value, 1'b0, $sformatf("rnd%0d", r));
            check_load($sformatf("rnd%0d", r), mode, value);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
